pr_ctrl: RTL and testbench

Sequencer for the partial-reconfiguration IP (pr_ip) in top. Accepts a start request, freezes and isolates the reconfigurable region (counters/7-seg/LED logic), streams a bitstream from a word source into pr_ip with a valid/ready handshake, then reports pass or fail. Releases the region through a reset pulse once reconfiguration completes.

---
 rtl/pr_ctrl_if.sv | 25 ++
 rtl/pr_ctrl.sv | 142 ++++++++++++++
 tb/tb_pr_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_ctrl_if.sv
// rtl/pr_ctrl_if.sv - bitstream source and pr_ip handshake bundle for pr_ctrl
interface pr_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_last;
    logic              src_ready;
    logic              pr_start;
    logic [DATA_W-1:0] pr_data;
    logic              pr_data_valid;
    logic              pr_data_ready;
    logic [2:0]        pr_status;
    logic              pr_freeze;

    modport master (
        output src_data, src_valid, src_last, pr_data_ready, pr_status, pr_freeze,
        input  src_ready, pr_start, pr_data, pr_data_valid
    );

    modport slave (
        input  src_data, src_valid, src_last, pr_data_ready, pr_status, pr_freeze,
        output src_ready, pr_start, pr_data, pr_data_valid
    );
endinterface

// File: rtl/pr_ctrl.sv
// rtl/pr_ctrl.sv - partial-reconfiguration sequencer: freeze, stream bitstream to pr_ip, report, release
// Optional WAIT_RESULT watchdog enabled by defining PR_CTRL_TIMEOUT_EN.
module pr_ctrl #(
    parameter int DATA_W         = 16,
    parameter int SETTLE_CYCLES  = 16,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    pr_ctrl_if.slave         bus,
    output logic             region_freeze,
    output logic             region_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] word_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_FREEZE, S_REQ, S_STREAM, S_WAIT, S_FAIL, S_UNFREEZE
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] settle_cnt;
    logic          settle_done;
    logic          xfer;
    logic          timeout;

    logic st_run;
    logic st_pass;
    logic st_fatal;
    logic st_err;

    assign st_run   = (bus.pr_status == 3'b100);
    assign st_pass  = (bus.pr_status == 3'b101);
    assign st_fatal = (bus.pr_status == 3'b001) || (bus.pr_status == 3'b010) ||
                      (bus.pr_status == 3'b011);
    // 000 is pr_ip's idle report, so it only counts as a failure once a result is awaited
    assign st_err   = !(st_run || st_pass || (bus.pr_status == 3'b000));

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign xfer        = bus.src_valid && bus.src_ready;

`ifdef PR_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state != S_WAIT) && (next_state == S_WAIT)) begin
            to_cnt <= TW'(TIMEOUT_CYCLES);
        end else if ((state == S_WAIT) && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign timeout = (state == S_WAIT) && (to_cnt == TW'(1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_FREEZE;
            S_FREEZE:   if (settle_done) next_state = S_REQ;
            S_REQ: begin
                if (st_run)        next_state = S_STREAM;
                else if (st_fatal) next_state = S_FAIL;
            end
            S_STREAM: begin
                if (st_err)                      next_state = S_FAIL;
                else if (xfer && bus.src_last)   next_state = S_WAIT;
            end
            S_WAIT: begin
                if (st_pass)                    next_state = S_UNFREEZE;
                else if (!st_run || timeout)    next_state = S_FAIL;
            end
            S_FAIL:     next_state = S_UNFREEZE;
            S_UNFREEZE: if (settle_done) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state != S_IDLE);
        region_freeze     = (state != S_IDLE);
        region_rst        = (state == S_UNFREEZE) && (settle_cnt == '0);
        bus.pr_start      = (state == S_REQ);
        bus.pr_data       = DATA_W'(bus.src_data);
        bus.pr_data_valid = bus.src_valid && (state == S_STREAM);
        // an error report blocks the word offered in the same cycle
        bus.src_ready     = bus.pr_data_ready && (state == S_STREAM) && !st_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 3'b000;
            word_cnt   <= '0;
        end else begin
            done <= (state == S_UNFREEZE) && (next_state == S_IDLE) && !error;

            if (state != next_state) begin
                settle_cnt <= '0;
            end else if ((state == S_FREEZE) || (state == S_UNFREEZE)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if ((state == S_IDLE) && start) begin
                error    <= 1'b0;
                err_code <= 3'b000;
                word_cnt <= '0;
            end else begin
                if (xfer) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                if ((next_state == S_FAIL) && (state != S_FAIL)) begin
                    error    <= 1'b1;
                    err_code <= timeout ? 3'b111 : bus.pr_status;
                end
            end
        end
    end
endmodule

// File: tb/tb_pr_ctrl.sv
// tb/tb_pr_ctrl.sv - directed self-checking bench for pr_ctrl
module tb_pr_ctrl;
    localparam int DW = 16;
    localparam int SC = 4;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          region_freeze, region_rst, busy, done, error;
    logic [2:0]    err_code;
    logic [CW-1:0] word_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pr_ctrl_if #(.DATA_W(DW)) bus ();

    pr_ctrl #(
        .DATA_W(DW), .SETTLE_CYCLES(SC), .CNT_W(CW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
        .region_freeze(region_freeze), .region_rst(region_rst), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start             = 1'b0;
        bus.src_data      = '0;
        bus.src_valid     = 1'b0;
        bus.src_last      = 1'b0;
        bus.pr_data_ready = 1'b1;
        bus.pr_status     = 3'b000;
        bus.pr_freeze     = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic to_stream;
        int c = 0;
        while (!bus.pr_start && c < 50) begin
            tick();
            c++;
        end
        n_checks++;
        if (bus.pr_start !== 1'b1) $display("FAIL to_stream: pr_start=%b required 1", bus.pr_start);
        else n_pass++;
        bus.pr_status = 3'b100;
        tick();
    endtask

    task automatic send_words(input int n, input logic [15:0] base, input logic with_last);
        for (int i = 0; i < n; i++) begin
            bus.src_data  = 16'(base + i);
            bus.src_valid = 1'b1;
            bus.src_last  = with_last && (i == n - 1);
            tick();
        end
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        bus.src_data  = '0;
    endtask

    task automatic wait_idle;
        int c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b required 0", busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, error, region_freeze, region_rst, bus.pr_start, bus.src_ready, bus.pr_data_valid} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {busy, done, error, region_freeze, region_rst, bus.pr_start, bus.src_ready, bus.pr_data_valid});
        else n_pass++;
        n_checks++;
        if (err_code !== 3'b000) $display("FAIL reset_err_code: got %b required 000", err_code);
        else n_pass++;
        n_checks++;
        if (word_cnt !== '0) $display("FAIL reset_word_cnt: got %0d required 0", word_cnt);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_success;
        int c;
        int bad;
        int extra_rst;
        pulse_start();
        n_checks++;
        if ({busy, region_freeze, bus.pr_start} !== 3'b110)
            $display("FAIL start_to_freeze: got %b required 110", {busy, region_freeze, bus.pr_start});
        else n_pass++;
        c = 0;
        while (!bus.pr_start && c < 20) begin
            tick();
            c++;
        end
        n_checks++;
        if (c !== SC) $display("FAIL freeze_len: got %0d cycles required %0d", c, SC);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.pr_start !== 1'b1) $display("FAIL req_hold: pr_start=%b required 1", bus.pr_start);
        else n_pass++;
        bus.pr_status = 3'b100;
        tick();
        n_checks++;
        if ({bus.pr_start, region_freeze} !== 2'b01)
            $display("FAIL stream_entry: got %b required 01", {bus.pr_start, region_freeze});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            bus.src_data  = 16'hA000 + 16'(i);
            bus.src_valid = 1'b1;
            bus.src_last  = (i == 7);
            #1;
            if (!(bus.src_ready === 1'b1 && bus.pr_data_valid === 1'b1 && bus.pr_data === (16'hA000 + 16'(i)))) bad++;
            tick();
        end
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL success_stream: %0d bad words required 0", bad);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 24'd8) $display("FAIL success_word_cnt: got %0d required 8", word_cnt);
        else n_pass++;
        bus.src_data  = 16'h5555;
        bus.src_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.src_ready, bus.pr_data_valid, busy} !== 3'b001)
            $display("FAIL after_last: got %b required 001", {bus.src_ready, bus.pr_data_valid, busy});
        else n_pass++;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.pr_status = 3'b101;
        tick();
        n_checks++;
        if ({region_rst, region_freeze} !== 2'b11)
            $display("FAIL unfreeze_entry: got %b required 11", {region_rst, region_freeze});
        else n_pass++;
        c = 0;
        extra_rst = 0;
        while (region_freeze && c < 20) begin
            tick();
            c++;
            if (region_rst) extra_rst++;
        end
        n_checks++;
        if (c !== SC) $display("FAIL unfreeze_len: got %0d cycles required %0d", c, SC);
        else n_pass++;
        n_checks++;
        if (extra_rst !== 0) $display("FAIL region_rst_width: %0d extra cycles required 0", extra_rst);
        else n_pass++;
        n_checks++;
        if ({done, error, busy} !== 3'b100) $display("FAIL done_pulse: got %b required 100", {done, error, busy});
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_width: done=%b required 0", done);
        else n_pass++;
        bus.pr_status = 3'b000;
    endtask

    task automatic test_backpressure;
        int idx = 0;
        int cyc = 0;
        int bad_accept = 0;
        int bad_order = 0;
        logic rdy;
        pulse_start();
        to_stream();
        while (idx < 6 && cyc < 40) begin
            rdy = (cyc % 2 == 0);
            bus.pr_data_ready = rdy;
            bus.src_data      = 16'hB000 + 16'(idx);
            bus.src_valid     = 1'b1;
            bus.src_last      = (idx == 5);
            #1;
            if (bus.src_ready !== rdy) bad_accept++;
            if (bus.pr_data !== (16'hB000 + 16'(idx))) bad_order++;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        bus.src_valid     = 1'b0;
        bus.src_last      = 1'b0;
        bus.pr_data_ready = 1'b1;
        n_checks++;
        if (idx !== 6) $display("FAIL bp_complete: sent %0d required 6", idx);
        else n_pass++;
        n_checks++;
        if (bad_accept !== 0) $display("FAIL bp_ready: %0d cycles with src_ready!=pr_data_ready required 0", bad_accept);
        else n_pass++;
        n_checks++;
        if (bad_order !== 0) $display("FAIL bp_order: %0d data mismatches required 0", bad_order);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 24'd6) $display("FAIL bp_word_cnt: got %0d required 6", word_cnt);
        else n_pass++;
        bus.pr_status = 3'b101;
        wait_idle();
        bus.pr_status = 3'b000;
    endtask

    task automatic test_crc_fail;
        int c = 0;
        logic saw_done = 1'b0;
        pulse_start();
        to_stream();
        send_words(2, 16'hC000, 1'b0);
        bus.src_data  = 16'hC002;
        bus.src_valid = 1'b1;
        bus.pr_status = 3'b010;
        #1;
        n_checks++;
        if (bus.src_ready !== 1'b0) $display("FAIL crc_ready: src_ready=%b required 0", bus.src_ready);
        else n_pass++;
        tick();
        bus.src_valid = 1'b0;
        n_checks++;
        if ({error, err_code, region_rst, busy} !== 6'b1_010_0_1)
            $display("FAIL crc_capture: got %b required 101001", {error, err_code, region_rst, busy});
        else n_pass++;
        tick();
        n_checks++;
        if (region_rst !== 1'b1) $display("FAIL crc_region_rst: got %b required 1", region_rst);
        else n_pass++;
        while (busy && c < 30) begin
            tick();
            c++;
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if ({saw_done, busy} !== 2'b00) $display("FAIL crc_no_done: got %b required 00", {saw_done, busy});
        else n_pass++;
        n_checks++;
        if ({error, err_code, word_cnt} !== {1'b1, 3'b010, 24'd2})
            $display("FAIL crc_sticky: error=%b err_code=%b word_cnt=%0d required 1 010 2", error, err_code, word_cnt);
        else n_pass++;
        bus.pr_status = 3'b000;
        tick();
    endtask

    task automatic test_start_busy;
        pulse_start();
        n_checks++;
        if ({error, err_code, word_cnt} !== '0)
            $display("FAIL start_clears: error=%b err_code=%b word_cnt=%0d required 0 000 0", error, err_code, word_cnt);
        else n_pass++;
        to_stream();
        send_words(3, 16'hD000, 1'b0);
        bus.src_data  = 16'hD003;
        bus.src_valid = 1'b1;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        bus.src_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, bus.pr_start, region_freeze, bus.src_ready} !== 4'b1011)
            $display("FAIL busy_start_state: got %b required 1011", {busy, bus.pr_start, region_freeze, bus.src_ready});
        else n_pass++;
        n_checks++;
        if (word_cnt !== 24'd4) $display("FAIL busy_start_cnt: got %0d required 4", word_cnt);
        else n_pass++;
        send_words(1, 16'hD004, 1'b1);
        n_checks++;
        if (word_cnt !== 24'd5) $display("FAIL busy_final_cnt: got %0d required 5", word_cnt);
        else n_pass++;
        bus.pr_status = 3'b101;
        wait_idle();
        bus.pr_status = 3'b000;
        n_checks++;
        if (error !== 1'b0) $display("FAIL busy_error: got %b required 0", error);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        logic saw = 1'b0;
        pulse_start();
        to_stream();
        send_words(2, 16'hE000, 1'b1);
        n_checks++;
        if ({busy, bus.pr_start, word_cnt} !== {2'b10, 24'd2})
            $display("FAIL ar_wait: busy=%b pr_start=%b word_cnt=%0d required 1 0 2", busy, bus.pr_start, word_cnt);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, error, region_freeze, region_rst, bus.pr_start, bus.src_ready, bus.pr_data_valid} !== 8'h00)
            $display("FAIL ar_outputs: got %b required 00000000",
                     {busy, done, error, region_freeze, region_rst, bus.pr_start, bus.src_ready, bus.pr_data_valid});
        else n_pass++;
        n_checks++;
        if ({err_code, word_cnt, bus.pr_data} !== '0)
            $display("FAIL ar_regs: err_code=%b word_cnt=%0d pr_data=%h required 0", err_code, word_cnt, bus.pr_data);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        bus.pr_status = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || region_rst || busy) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL ar_quiet: activity after reset=%b required 0", saw);
        else n_pass++;
    endtask

`ifdef PR_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int c = 0;
        pulse_start();
        to_stream();
        send_words(1, 16'hF000, 1'b1);
        while (!error && c < 200) begin
            tick();
            c++;
        end
        n_checks++;
        if (c !== 100) $display("FAIL timeout_len: got %0d cycles required 100", c);
        else n_pass++;
        n_checks++;
        if ({error, err_code} !== 4'b1111) $display("FAIL timeout_code: got %b required 1111", {error, err_code});
        else n_pass++;
        bus.pr_status = 3'b000;
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_success();
        test_backpressure();
        test_crc_fail();
        test_start_busy();
        test_async_reset();
`ifdef PR_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
